// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the fetch/decode datapath.
// NOP encoding and default datapath width reused by reg_d/reg_e and hazard unit.
package pipeline_pkg;

    localparam int unsigned PIPE_DATA_W = 32;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fq_store.sv
// Register-array storage for the fetch queue.
// Ports: clk; we/waddr/wdata sync write; raddr -> rdata async read.
import pipeline_pkg::*;

module fq_store #(
    parameter int unsigned WIDTH = 2 * PIPE_DATA_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and the decode register.
// Ports: clk, reset, flush; push_* from fetch; pop_* to decode; count/full/empty status.
import pipeline_pkg::*;

module fetch_queue #(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_instr,
    input  logic [DATA_W-1:0] push_pc_plus_4,
    output logic              push_ready,
    input  logic              pop_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_instr,
    output logic [DATA_W-1:0] pop_pc_plus_4,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count_q;
    logic [2*DATA_W-1:0] rdata;
    logic                kill;
    logic                bypass_path;
    logic                head_valid;
    logic                push_fire;
    logic                pop_fire;
    logic                pass_through;
    logic                do_write;
    logic                do_read;

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign kill  = reset | flush;

    // Push acceptance never looks at pop_ready.
    assign push_ready = !full && !kill;

    assign bypass_path = BYPASS && empty;
    assign head_valid  = !empty || (bypass_path && push_valid);
    assign pop_valid   = head_valid && !kill;

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;

    // Empty + bypass + consumed: data skips the store entirely.
    assign pass_through = bypass_path && push_fire && pop_ready;
    assign do_write     = push_fire && !pass_through;
    assign do_read      = pop_fire && !pass_through;

    always_comb begin
        pop_instr     = DATA_W'(NOP_INSTR);
        pop_pc_plus_4 = '0;
        if (pop_valid) begin
            if (bypass_path) begin
                pop_instr     = push_instr;
                pop_pc_plus_4 = push_pc_plus_4;
            end else begin
                pop_instr     = rdata[2*DATA_W-1:DATA_W];
                pop_pc_plus_4 = rdata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case (1'b1)
                do_write && !do_read: count_q <= count_q + CW'(1);
                do_read && !do_write: count_q <= count_q - CW'(1);
                default:              count_q <= count_q;
            endcase
        end
    end

    fq_store #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata ({push_instr, push_pc_plus_4}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: bypass and registered variants side by side.
// Queue-list model checked every cycle plus literal spot checks.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_instr = '0;
    logic [31:0] push_pc_plus_4 = '0;
    logic        pop_ready = 1'b0;

    // index 0: BYPASS=1, index 1: BYPASS=0
    logic        o_pr    [2];
    logic        o_pv    [2];
    logic [31:0] o_pi    [2];
    logic [31:0] o_pc    [2];
    logic [2:0]  o_cnt   [2];
    logic        o_full  [2];
    logic        o_empty [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DATA_W(32), .DEPTH(4), .BYPASS(1'b1)) u_b1 (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_instr(push_instr),
        .push_pc_plus_4(push_pc_plus_4), .push_ready(o_pr[0]),
        .pop_ready(pop_ready), .pop_valid(o_pv[0]),
        .pop_instr(o_pi[0]), .pop_pc_plus_4(o_pc[0]),
        .count(o_cnt[0]), .full(o_full[0]), .empty(o_empty[0])
    );

    fetch_queue #(.DATA_W(32), .DEPTH(4), .BYPASS(1'b0)) u_b0 (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_instr(push_instr),
        .push_pc_plus_4(push_pc_plus_4), .push_ready(o_pr[1]),
        .pop_ready(pop_ready), .pop_valid(o_pv[1]),
        .pop_instr(o_pi[1]), .pop_pc_plus_4(o_pc[1]),
        .count(o_cnt[1]), .full(o_full[1]), .empty(o_empty[1])
    );

    task automatic chk(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] at %0t: got %h expected %h",
                     nm, i, $time, act, exp);
        end
    endtask

    // Model: ordered list of stored {instr,pc} pairs per DUT.
    logic [63:0] mq [2][16];
    int          mn [2] = '{0, 0};

    bit          e_pr, e_pv, bp, take_push;
    logic [31:0] e_pi, e_pc;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bp   = (i == 0);
            e_pr = !reset && !flush && (mn[i] < 4);
            e_pv = 1'b0;
            e_pi = 32'h0;
            e_pc = 32'h0;
            if (!reset && !flush) begin
                if (mn[i] > 0) begin
                    e_pv = 1'b1;
                    {e_pi, e_pc} = mq[i][0];
                end else if (bp && push_valid) begin
                    e_pv = 1'b1;
                    e_pi = push_instr;
                    e_pc = push_pc_plus_4;
                end
            end
            chk("push_ready", i, 64'(o_pr[i]), 64'(e_pr));
            chk("pop_valid", i, 64'(o_pv[i]), 64'(e_pv));
            chk("pop_instr", i, 64'(o_pi[i]), 64'(e_pi));
            chk("pop_pc", i, 64'(o_pc[i]), 64'(e_pc));
            chk("count", i, 64'(o_cnt[i]), 64'(mn[i]));
            chk("full", i, 64'(o_full[i]), 64'(mn[i] == 4));
            chk("empty", i, 64'(o_empty[i]), 64'(mn[i] == 0));
            // state after the coming edge
            if (reset || flush) begin
                mn[i] = 0;
            end else begin
                take_push = push_valid && e_pr;
                if (e_pv && pop_ready) begin
                    if (mn[i] > 0) begin
                        for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
                        mn[i]--;
                    end else begin
                        take_push = 1'b0;
                    end
                end
                if (take_push) begin
                    mq[i][mn[i]] = {push_instr, push_pc_plus_4};
                    mn[i]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pv, input logic [31:0] ins,
                         input logic [31:0] pc, input bit pr);
        push_valid     = pv;
        push_instr     = ins;
        push_pc_plus_4 = pc;
        pop_ready      = pr;
    endtask

    initial begin
        // reset
        cyc();
        cyc();
        #1;
        chk("rst_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("rst_pv", 1, 64'(o_pv[1]), 64'd0);
        chk("rst_pr", 0, 64'(o_pr[0]), 64'd0);
        reset = 1'b0;
        #1;

        // 1: fill with pop_ready low
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h2001_0005 + k, 32'h0040_0004 + 4 * k, 0);
            cyc();
        end
        drive(0, 0, 0, 0);
        #1;
        chk("fill_count", 0, 64'(o_cnt[0]), 64'd4);
        chk("fill_full", 1, 64'(o_full[1]), 64'd1);
        chk("fill_pr", 0, 64'(o_pr[0]), 64'd0);
        drive(1, 32'hDEAD_BEEF, 32'h0000_1234, 0);
        cyc();
        drive(0, 0, 0, 0);
        #1;
        chk("refused_count", 1, 64'(o_cnt[1]), 64'd4);
        chk("refused_head", 0, 64'(o_pi[0]), 64'h2001_0005);

        // 2: drain in order
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1);
            #1;
            chk("drain_b1", 0, 64'(o_pi[0]), 64'(32'h2001_0005 + k));
            chk("drain_b0", 1, 64'(o_pc[1]), 64'(32'h0040_0004 + 4 * k));
            cyc();
        end
        #1;
        chk("drained_empty", 0, 64'(o_empty[0]), 64'd1);
        chk("drained_instr", 1, 64'(o_pi[1]), 64'h0);

        // 3: bypass vs registered
        drive(1, 32'h8C08_0000, 32'h0040_0100, 1);
        #1;
        chk("byp_instr", 0, 64'(o_pi[0]), 64'h8C08_0000);
        chk("nobyp_pv", 1, 64'(o_pv[1]), 64'd0);
        cyc();
        drive(0, 0, 0, 1);
        #1;
        chk("byp_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("nobyp_pv_next", 1, 64'(o_pv[1]), 64'd1);
        chk("nobyp_instr", 1, 64'(o_pi[1]), 64'h8C08_0000);
        cyc();

        // 4: flush mid-stream
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1000_0000 + k, 32'h0050_0000 + 4 * k, 0);
            cyc();
        end
        drive(1, 32'h1000_00FF, 32'h0050_00FF, 1);
        flush = 1'b1;
        #1;
        chk("flush_pv", 0, 64'(o_pv[0]), 64'd0);
        chk("flush_pr", 1, 64'(o_pr[1]), 64'd0);
        cyc();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("flush_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("flush_count", 1, 64'(o_cnt[1]), 64'd0);

        // 5: wrap-around at steady count 2
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h3000_0000 + k, 32'h0060_0000 + 4 * k, 0);
            cyc();
        end
        for (int k = 2; k < 12; k++) begin
            drive(1, 32'h3000_0000 + k, 32'h0060_0000 + 4 * k, 1);
            cyc();
        end
        drive(0, 0, 0, 0);
        #1;
        chk("wrap_count", 0, 64'(o_cnt[0]), 64'd2);
        chk("wrap_head", 1, 64'(o_pi[1]), 64'h3000_000A);

        // 6: reset mid-operation at count 3
        drive(1, 32'h3000_000C, 32'h0060_0030, 0);
        cyc();
        drive(1, 32'h4000_0000, 32'h0070_0000, 1);
        reset = 1'b1;
        flush = 1'b1;
        #1;
        chk("rst_mid_pv", 0, 64'(o_pv[0]), 64'd0);
        chk("rst_mid_instr", 1, 64'(o_pi[1]), 64'h0);
        cyc();
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_mid_count", 1, 64'(o_cnt[1]), 64'd0);
        drive(1, 32'h5000_0001, 32'h0080_0004, 0);
        cyc();
        drive(0, 0, 0, 1);
        #1;
        chk("post_rst_head", 0, 64'(o_pi[0]), 64'h5000_0001);
        chk("post_rst_head", 1, 64'(o_pi[1]), 64'h5000_0001);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
